// File: rtl/snake_plot_arbiter.sv
// Round-robin owner of the VGA single-pixel plot port. Each granted requester gets
// one CELL_SIZE x CELL_SIZE block painted in raster order, followed by an ack pulse.
module snake_plot_arbiter #(
    parameter int CELL_SIZE = 4,
    parameter int CELL_X_W  = 6,
    parameter int CELL_Y_W  = 5,
    parameter int COLOR_W   = 3
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic [2:0]               req,
    input  logic [3*CELL_X_W-1:0]    req_x,
    input  logic [3*CELL_Y_W-1:0]    req_y,
    input  logic [3*COLOR_W-1:0]     req_colour,
    output logic [2:0]               ack,
    output logic                     busy,
    output logic                     plot,
    output logic [7:0]               vga_x,
    output logic [6:0]               vga_y,
    output logic [COLOR_W-1:0]       vga_colour
);

    localparam int CS_W = $clog2(CELL_SIZE);
    localparam logic [CS_W-1:0] C_MAX = CS_W'(CELL_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_r, state_n;
    logic [CS_W-1:0]       cx_r, cx_n;
    logic [CS_W-1:0]       cy_r, cy_n;
    logic [CELL_X_W-1:0]   cap_x_r, cap_x_n;
    logic [CELL_Y_W-1:0]   cap_y_r, cap_y_n;
    logic [COLOR_W-1:0]    cap_colour_r, cap_colour_n;
    logic [1:0]            grant_r, grant_n;
    logic [1:0]            last_grant_r, last_grant_n;
    logic [1:0]            win_s;

    logic                  plot_r, plot_n;
    logic                  busy_r, busy_n;
    logic [2:0]            ack_r, ack_n;
    logic [7:0]            vga_x_r, vga_x_n;
    logic [6:0]            vga_y_r, vga_y_n;
    logic [COLOR_W-1:0]    vga_colour_r, vga_colour_n;

    // Round-robin pick: search starts one past the last served requester.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] p0, p1, p2;
        logic [1:0] pick;
        case (last)
            2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
        if (r[p0]) begin
            pick = p0;
        end else if (r[p1]) begin
            pick = p1;
        end else begin
            pick = p2;
        end
        return pick;
    endfunction

    function automatic logic [7:0] pix_x(input logic [CELL_X_W-1:0] c, input logic [CS_W-1:0] o);
        return 8'({c, {CS_W{1'b0}}}) + 8'(o);
    endfunction

    function automatic logic [6:0] pix_y(input logic [CELL_Y_W-1:0] c, input logic [CS_W-1:0] o);
        return 7'({c, {CS_W{1'b0}}}) + 7'(o);
    endfunction

    function automatic logic [2:0] one_hot3(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Next-state: sample requests only in IDLE, walk the block in DRAW, retire in DONE.
    always_comb begin
        state_n      = state_r;
        cx_n         = cx_r;
        cy_n         = cy_r;
        cap_x_n      = cap_x_r;
        cap_y_n      = cap_y_r;
        cap_colour_n = cap_colour_r;
        grant_n      = grant_r;
        last_grant_n = last_grant_r;
        win_s        = rr_pick(req, last_grant_r);
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_n      = ST_DRAW;
                    grant_n      = win_s;
                    cap_x_n      = req_x[int'(win_s)*CELL_X_W +: CELL_X_W];
                    cap_y_n      = req_y[int'(win_s)*CELL_Y_W +: CELL_Y_W];
                    cap_colour_n = req_colour[int'(win_s)*COLOR_W +: COLOR_W];
                    cx_n         = '0;
                    cy_n         = '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DRAW: begin
                cx_n = cx_r + CS_W'(1);
                if (cx_r == C_MAX) begin
                    cy_n = cy_r + CS_W'(1);
                    if (cy_r == C_MAX) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_DRAW;
                    end
                end else begin
                    cy_n = cy_r;
                end
            end
            ST_DONE: begin
                state_n      = ST_IDLE;
                last_grant_n = grant_r;
                cx_n         = '0;
                cy_n         = '0;
            end
            default: begin
                state_n = ST_IDLE;
                cx_n    = '0;
                cy_n    = '0;
            end
        endcase
    end

    // Outputs are precomputed from next state so the first pixel appears on the grant edge.
    always_comb begin
        plot_n       = (state_n == ST_DRAW);
        busy_n       = (state_n != ST_IDLE);
        vga_x_n      = 8'd0;
        vga_y_n      = 7'd0;
        vga_colour_n = '0;
        ack_n        = 3'b000;
        if (state_n == ST_DRAW) begin
            vga_x_n      = pix_x(cap_x_n, cx_n);
            vga_y_n      = pix_y(cap_y_n, cy_n);
            vga_colour_n = cap_colour_n;
        end else if (state_n == ST_DONE) begin
            ack_n = one_hot3(grant_n);
        end else begin
            ack_n = 3'b000;
        end
    end

    // State and output registers; reset abandons any block in flight without an ack.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cx_r         <= '0;
            cy_r         <= '0;
            cap_x_r      <= '0;
            cap_y_r      <= '0;
            cap_colour_r <= '0;
            grant_r      <= 2'd0;
            last_grant_r <= 2'd2;
            plot_r       <= 1'b0;
            busy_r       <= 1'b0;
            ack_r        <= 3'b000;
            vga_x_r      <= 8'd0;
            vga_y_r      <= 7'd0;
            vga_colour_r <= '0;
        end else begin
            state_r      <= state_n;
            cx_r         <= cx_n;
            cy_r         <= cy_n;
            cap_x_r      <= cap_x_n;
            cap_y_r      <= cap_y_n;
            cap_colour_r <= cap_colour_n;
            grant_r      <= grant_n;
            last_grant_r <= last_grant_n;
            plot_r       <= plot_n;
            busy_r       <= busy_n;
            ack_r        <= ack_n;
            vga_x_r      <= vga_x_n;
            vga_y_r      <= vga_y_n;
            vga_colour_r <= vga_colour_n;
        end
    end

    assign plot       = plot_r;
    assign busy       = busy_r;
    assign ack        = ack_r;
    assign vga_x      = vga_x_r;
    assign vga_y      = vga_y_r;
    assign vga_colour = vga_colour_r;

endmodule

// File: tb/tb_snake_plot_arbiter.sv
// Directed bench for snake_plot_arbiter: block rasterisation, round-robin order,
// ack timing, request drop and asynchronous reset behaviour.
module tb_snake_plot_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [17:0] req_x = 18'd0;
    logic [14:0] req_y = 15'd0;
    logic [8:0]  req_colour = 9'd0;
    logic [2:0]  ack;
    logic        busy;
    logic        plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int ack_cyc = 0;
    int prev_ack = 0;

    snake_plot_arbiter #(
        .CELL_SIZE (4),
        .CELL_X_W  (6),
        .CELL_Y_W  (5),
        .COLOR_W   (3)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .ack        (ack),
        .busy       (busy),
        .plot       (plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input int x, input int y, input int c);
        req_x[i*6 +: 6]      = 6'(x);
        req_y[i*5 +: 5]      = 5'(y);
        req_colour[i*3 +: 3] = 3'(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 3'b000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_plot"}, plot, 0);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_x"}, vga_x, 0);
        check({tag, "_y"}, vga_y, 0);
        check({tag, "_colour"}, vga_colour, 0);
    endtask

    // Follows one block from its first pixel to the DONE cycle; returns at the DONE negedge.
    task automatic run_block(input int g, input int bx, input int by, input int col,
                             input logic [2:0] drop_mask, input int drop_at);
        int n = 0;
        while (!plot && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("plot_start", plot, 1);
        for (int k = 0; k < 16; k++) begin
            check("plot", plot, 1);
            check("vga_x", vga_x, bx * 4 + k % 4);
            check("vga_y", vga_y, by * 4 + k / 4);
            check("colour", vga_colour, col);
            check("busy", busy, 1);
            check("ack_low", ack, 0);
            if (k == drop_at) req = req & ~drop_mask;
            @(negedge clk);
        end
        check("ack", ack, 1 << g);
        check("done_plot", plot, 0);
        check("done_busy", busy, 1);
        check("done_colour", vga_colour, 0);
        ack_cyc = cyc;
        req = req & ~drop_mask;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        // Single request
        @(negedge clk);
        set_req(0, 2, 3, 4);
        req = 3'b001;
        run_block(0, 2, 3, 4, 3'b001, -1);
        @(negedge clk);
        check("after_ack", ack, 0);
        check("after_busy", busy, 0);
        check("after_plot", plot, 0);

        // Simultaneous requests: 0, 1, 2 with 18-cycle ack spacing
        do_reset();
        set_req(0, 1, 1, 1);
        set_req(1, 2, 2, 2);
        set_req(2, 3, 3, 3);
        req = 3'b111;
        run_block(0, 1, 1, 1, 3'b001, -1);
        prev_ack = ack_cyc;
        run_block(1, 2, 2, 2, 3'b010, -1);
        check("ack_gap01", ack_cyc - prev_ack, 18);
        prev_ack = ack_cyc;
        run_block(2, 3, 3, 3, 3'b100, -1);
        check("ack_gap12", ack_cyc - prev_ack, 18);

        // Fairness: req0 re-raised after each ack, req1 held
        do_reset();
        set_req(0, 4, 4, 5);
        set_req(1, 6, 6, 6);
        req = 3'b011;
        for (int r = 0; r < 2; r++) begin
            run_block(0, 4, 4, 5, 3'b001, -1);
            @(negedge clk);
            req[0] = 1'b1;
            run_block(1, 6, 6, 6, 3'b000, -1);
        end
        req = 3'b000;

        // Corner cell
        do_reset();
        set_req(2, 39, 29, 7);
        req = 3'b100;
        run_block(2, 39, 29, 7, 3'b100, -1);

        // Request dropped after the 5th plot cycle still completes
        do_reset();
        set_req(0, 5, 6, 2);
        req = 3'b001;
        run_block(0, 5, 6, 2, 3'b001, 4);

        // Reset on the 8th plot cycle
        do_reset();
        set_req(0, 7, 7, 3);
        req = 3'b001;
        n = 0;
        while (!plot && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_start", plot, 1);
        repeat (7) @(negedge clk);
        check("rst_mid_x_pre", vga_x, 28 + 3);
        reset = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 1, 2, 6);
        set_req(1, 3, 4, 5);
        req = 3'b011;
        run_block(0, 1, 2, 6, 3'b001, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
